// File: rtl/multi_lane_compact_fifo_axi.sv
// multi_lane_compact_fifo_axi
// AXI4-Stream lane-compacting FIFO. Lanes of each input beat whose keep is
// all-zero are dropped; surviving lanes are stored gap-free as {data, keep, last}
// entries in a circular lane buffer and re-emitted as OUT_LANES-wide beats.
// An output beat never spans two packets: a last entry closes the beat early.
// Optional feature: define MULTI_LANE_COMPACT_TIMEOUT_EN to flush sub-beat
// residue as a partial beat (tlast=0) after FLUSH_CYCLES idle cycles.
module multi_lane_compact_fifo_axi #(
    parameter int DEPTH        = 32,
    parameter int DATA_WIDTH   = 64,
    parameter int IN_LANES     = 4,
    parameter int OUT_LANES    = 2,
    parameter int FLUSH_CYCLES = 16
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [IN_LANES*DATA_WIDTH-1:0]    i_data_tdata,
    input  logic [IN_LANES*DATA_WIDTH/8-1:0]  i_data_tkeep,
    input  logic                              i_data_tlast,
    input  logic                              i_data_tvalid,
    output logic                              i_data_tready,
    output logic [OUT_LANES*DATA_WIDTH-1:0]   o_data_tdata,
    output logic [OUT_LANES*DATA_WIDTH/8-1:0] o_data_tkeep,
    output logic                              o_data_tlast,
    output logic                              o_data_tvalid,
    input  logic                              o_data_tready,
    output logic [$clog2(DEPTH):0]            filling_level
);
    localparam int KW = DATA_WIDTH / 8;
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int EW = DATA_WIDTH + KW + 1;

    // Entry layout: {data, keep, last}
    logic [EW-1:0]       mem [DEPTH];
    logic [PW-1:0]       wr_ptr;
    logic [PW-1:0]       rd_ptr;
    logic [CW-1:0]       count;
    logic [CW-1:0]       count_nxt;
    logic                wr_en;

    logic [IN_LANES-1:0] occ;
    logic [IN_LANES-1:0] lane_last;
    logic [PW-1:0]       wr_idx [IN_LANES];
    logic [CW-1:0]       n_push;
    logic                null_last;
    logic                above;

    logic [EW-1:0]       head [OUT_LANES];
    logic [CW-1:0]       n_pop;
    logic                pop_last;
    logic                found;
    logic                load;
    logic                flush;
    logic [OUT_LANES*DATA_WIDTH-1:0] nxt_data;
    logic [OUT_LANES*KW-1:0]         nxt_keep;

    assign wr_en         = i_data_tvalid && i_data_tready;
    assign load          = !o_data_tvalid || o_data_tready;
    assign count_nxt     = count + (wr_en ? n_push : '0) - n_pop;
    assign filling_level = count;

    // Lane occupancy, compacted write slots and placement of the packet's last flag
    always_comb begin
        n_push    = '0;
        above     = 1'b0;
        occ       = '0;
        lane_last = '0;
        for (int k = 0; k < IN_LANES; k++) begin
            occ[k]    = |i_data_tkeep[k*KW +: KW];
            wr_idx[k] = wr_ptr + n_push[PW-1:0];
            if (occ[k]) n_push = n_push + CW'(1);
        end
        for (int k = IN_LANES - 1; k >= 0; k--) begin
            lane_last[k] = i_data_tlast && occ[k] && !above;
            if (occ[k]) above = 1'b1;
        end
        // A terminated beat with no surviving lanes still needs a packet boundary
        null_last = i_data_tlast && (occ == '0);
        if (null_last) n_push = CW'(1);
    end

    // Buffer storage: compacted lanes, or a single null terminator entry
    always_ff @(posedge clk) begin
        if (wr_en) begin
            if (null_last) begin
                mem[wr_ptr] <= EW'(1);
            end else begin
                for (int k = 0; k < IN_LANES; k++) begin
                    if (occ[k]) begin
                        mem[wr_idx[k]] <= {i_data_tdata[k*DATA_WIDTH +: DATA_WIDTH],
                                           i_data_tkeep[k*KW +: KW], lane_last[k]};
                    end
                end
            end
        end
    end

    // Head-window scan: pop a full group, a group closed by a last entry, or a flushed residue
    always_comb begin
        n_pop    = '0;
        pop_last = 1'b0;
        found    = 1'b0;
        nxt_data = '0;
        nxt_keep = '0;
        for (int j = 0; j < OUT_LANES; j++) begin
            head[j] = mem[rd_ptr + PW'(j)];
        end
        for (int j = 0; j < OUT_LANES; j++) begin
            if (!found && (CW'(j) < count) && head[j][0]) begin
                n_pop    = CW'(j + 1);
                pop_last = 1'b1;
                found    = 1'b1;
            end
        end
        if (!found) begin
            if (count >= CW'(OUT_LANES)) n_pop = CW'(OUT_LANES);
            else if (flush)              n_pop = count;
        end
        if (!load) begin
            n_pop    = '0;
            pop_last = 1'b0;
        end
        for (int j = 0; j < OUT_LANES; j++) begin
            if (CW'(j) < n_pop) begin
                nxt_data[j*DATA_WIDTH +: DATA_WIDTH] = head[j][EW-1 -: DATA_WIDTH];
                nxt_keep[j*KW +: KW]                 = head[j][KW:1];
            end
        end
    end

    // Pointers, occupancy and input ready (registered from the post-edge occupancy)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            i_data_tready <= 1'b0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + n_push[PW-1:0];
            rd_ptr        <= rd_ptr + n_pop[PW-1:0];
            count         <= count_nxt;
            i_data_tready <= (count_nxt <= CW'(DEPTH - IN_LANES));
        end
    end

    // Output stage: loads a new group whenever the current beat is empty or accepted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_data_tvalid <= 1'b0;
            o_data_tdata  <= '0;
            o_data_tkeep  <= '0;
            o_data_tlast  <= 1'b0;
        end else if (load) begin
            o_data_tvalid <= (n_pop != '0);
            o_data_tdata  <= nxt_data;
            o_data_tkeep  <= nxt_keep;
            o_data_tlast  <= pop_last;
        end
    end

`ifdef MULTI_LANE_COMPACT_TIMEOUT_EN
    localparam int IW = $clog2(FLUSH_CYCLES + 1);
    logic [IW-1:0] idle_cnt;
    logic          idle_tick;

    assign idle_tick = (count != '0) && (count < CW'(OUT_LANES)) && !wr_en;
    assign flush     = idle_tick && (idle_cnt == IW'(FLUSH_CYCLES - 1));

    // Idle counter: flush fires on the cycle the count reaches FLUSH_CYCLES, then holds until popped
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_cnt <= '0;
        end else if (wr_en || (n_pop != '0)) begin
            idle_cnt <= '0;
        end else if (idle_tick && !flush) begin
            idle_cnt <= idle_cnt + IW'(1);
        end
    end
`else
    logic unused_flush_cfg;
    assign flush            = 1'b0;
    assign unused_flush_cfg = (FLUSH_CYCLES > 0);
`endif

    // Occupancy never exceeds the buffer, and ready implies room for a full input beat
    assert property (@(posedge clk) disable iff (!rst_n) count <= CW'(DEPTH));
    assert property (@(posedge clk) disable iff (!rst_n)
                     i_data_tready |-> (count <= CW'(DEPTH - IN_LANES)));

endmodule

// File: tb/tb_multi_lane_compact_fifo_axi.sv
// Testbench for multi_lane_compact_fifo_axi (DEPTH=8, 16-bit lanes, 4 in / 2 out).
// Expected output beats go into a scoreboard queue; a monitor on the falling
// edge pops and compares every accepted output beat.
module tb_multi_lane_compact_fifo_axi;
    localparam int DEPTH = 8;
    localparam int DW    = 16;
    localparam int IL    = 4;
    localparam int OL    = 2;
    localparam int FC    = 16;
    localparam int KW    = DW / 8;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic [IL*DW-1:0]      i_tdata;
    logic [IL*KW-1:0]      i_tkeep;
    logic                  i_tlast;
    logic                  i_tvalid;
    logic                  i_tready;
    logic [OL*DW-1:0]      o_tdata;
    logic [OL*KW-1:0]      o_tkeep;
    logic                  o_tlast;
    logic                  o_tvalid;
    logic                  o_tready;
    logic [$clog2(DEPTH):0] filling_level;

    typedef struct packed {
        logic [OL*DW-1:0] data;
        logic [OL*KW-1:0] keep;
        logic             last;
    } beat_t;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [KW-1:0] keep;
        logic          last;
    } ent_t;

    beat_t exp_q[$];
    ent_t  model_q[$];
    int    n_checks = 0;
    int    n_pass   = 0;

    always #5 clk = ~clk;

    multi_lane_compact_fifo_axi #(
        .DEPTH(DEPTH), .DATA_WIDTH(DW), .IN_LANES(IL), .OUT_LANES(OL), .FLUSH_CYCLES(FC)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_data_tdata (i_tdata),
        .i_data_tkeep (i_tkeep),
        .i_data_tlast (i_tlast),
        .i_data_tvalid(i_tvalid),
        .i_data_tready(i_tready),
        .o_data_tdata (o_tdata),
        .o_data_tkeep (o_tkeep),
        .o_data_tlast (o_tlast),
        .o_data_tvalid(o_tvalid),
        .o_data_tready(o_tready),
        .filling_level(filling_level)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic beat_t mk(input logic [OL*DW-1:0] d, input logic [OL*KW-1:0] k,
                                 input logic l);
        beat_t b;
        b.data = d;
        b.keep = k;
        b.last = l;
        return b;
    endfunction

    // Reference model of compaction and grouping for generated traffic
    function automatic void model_add(input logic [IL*DW-1:0] d, input logic [IL*KW-1:0] k,
                                      input logic l);
        int    hi = -1;
        ent_t  e;
        beat_t b;
        for (int i = 0; i < IL; i++) if (|k[i*KW +: KW]) hi = i;
        for (int i = 0; i < IL; i++) begin
            if (|k[i*KW +: KW]) begin
                e.data = d[i*DW +: DW];
                e.keep = k[i*KW +: KW];
                e.last = l && (i == hi);
                model_q.push_back(e);
            end
        end
        if (l && hi < 0) begin
            e      = '0;
            e.last = 1'b1;
            model_q.push_back(e);
        end
        while (model_q.size() > 0) begin
            if (model_q[0].last) begin
                b = mk({DW'(0), model_q[0].data}, {KW'(0), model_q[0].keep}, 1'b1);
                exp_q.push_back(b);
                void'(model_q.pop_front());
            end else if (model_q.size() >= 2) begin
                b = mk({model_q[1].data, model_q[0].data}, {model_q[1].keep, model_q[0].keep},
                       model_q[1].last);
                exp_q.push_back(b);
                void'(model_q.pop_front());
                void'(model_q.pop_front());
            end else begin
                break;
            end
        end
    endfunction

    task automatic send(input logic [IL*DW-1:0] d, input logic [IL*KW-1:0] k, input logic l);
        int waited = 0;
        i_tdata  = d;
        i_tkeep  = k;
        i_tlast  = l;
        i_tvalid = 1'b1;
        forever begin
            @(negedge clk);
            if (i_tready) begin
                @(posedge clk);
                break;
            end
            waited++;
            if (waited > 500) begin
                n_checks++;
                $display("FAIL send_handshake: tready stayed %b for %0d cycles, required 1",
                         i_tready, waited);
                break;
            end
        end
        #1 i_tvalid = 1'b0;
    endtask

    task automatic send_model(input logic [IL*DW-1:0] d, input logic [IL*KW-1:0] k,
                              input logic l);
        send(d, k, l);
        model_add(d, k, l);
    endtask

    task automatic push_pattern(input int k);
        logic [3:0]       pats [4] = '{4'b0111, 4'b1011, 4'b1101, 4'b1110};
        logic [IL*DW-1:0] d;
        logic [IL*KW-1:0] kp;
        logic [3:0]       occ;
        occ = pats[k % 4];
        d   = '0;
        kp  = '0;
        for (int l = 0; l < IL; l++) begin
            d[l*DW +: DW] = DW'(16'hD000 + k * 16 + l);
            if (occ[l]) kp[l*KW +: KW] = ((k + l) % 3 == 0) ? 2'b01 : 2'b11;
        end
        send_model(d, kp, (k % 5) == 4);
    endtask

    task automatic drain(input string name, input int max_cycles);
        int c = 0;
        while (exp_q.size() != 0 && c < max_cycles) begin
            @(posedge clk);
            c++;
        end
        repeat (3) @(posedge clk);
        #1;
        check(name, 64'(exp_q.size()), 64'd0);
    endtask

    // Monitor: compare each accepted beat and hold-stability while stalled
    beat_t got;
    beat_t want;
    beat_t held;
    logic  stalled = 1'b0;
    always @(negedge clk) begin
        got = mk(o_tdata, o_tkeep, o_tlast);
        if (rst_n && o_tvalid && o_tready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL out_beat: got unexpected beat %h, required no beat", got);
            end else begin
                want = exp_q.pop_front();
                check("out_beat", 64'(got), 64'(want));
            end
        end
        if (rst_n && o_tvalid && !o_tready) begin
            if (stalled) check("stall_stable", 64'(got), 64'(held));
            stalled = 1'b1;
            held    = got;
        end else begin
            stalled = 1'b0;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int c;
        rst_n    = 1'b0;
        i_tvalid = 1'b0;
        i_tdata  = '0;
        i_tkeep  = '0;
        i_tlast  = 1'b0;
        o_tready = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_tvalid", 64'(o_tvalid), 64'd0);
        check("rst_outregs", 64'({o_tdata, o_tkeep, o_tlast}), 64'd0);
        check("rst_tready", 64'(i_tready), 64'd0);
        check("rst_fill", 64'(filling_level), 64'd0);
        @(negedge clk) rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("tready_after_rst", 64'(i_tready), 64'd1);

        // Sparse compaction: keeps 1010 then 0101 with tlast
        exp_q.push_back(mk({16'hA004, 16'hA002}, 4'b1111, 1'b0));
        exp_q.push_back(mk({16'hA007, 16'hA005}, 4'b1111, 1'b1));
        send({16'hA004, 16'hA003, 16'hA002, 16'hA001}, 8'b11001100, 1'b0);
        send({16'hA008, 16'hA007, 16'hA006, 16'hA005}, 8'b00110011, 1'b1);
        drain("drain_sparse", 50);

        // Null last after three stored lanes X,Y,Z
        exp_q.push_back(mk({16'hB002, 16'hB001}, 4'b1111, 1'b0));
        exp_q.push_back(mk({16'h0000, 16'hB003}, 4'b0011, 1'b1));
        send({16'h0000, 16'hB003, 16'hB002, 16'hB001}, 8'b00111111, 1'b0);
        send(64'hFFFF_EEEE_DDDD_CCCC, 8'b00000000, 1'b1);
        drain("drain_null", 50);

        // Full / backpressure: output register holds P, buffer fills with Q and R
        @(posedge clk);
        #1 o_tready = 1'b0;
        exp_q.push_back(mk({16'hC002, 16'hC001}, 4'b1111, 1'b0));
        exp_q.push_back(mk({16'hC012, 16'hC011}, 4'b1111, 1'b0));
        exp_q.push_back(mk({16'hC014, 16'hC013}, 4'b1111, 1'b0));
        exp_q.push_back(mk({16'hC022, 16'hC021}, 4'b1111, 1'b0));
        exp_q.push_back(mk({16'hC024, 16'hC023}, 4'b1111, 1'b0));
        send({16'h0000, 16'h0000, 16'hC002, 16'hC001}, 8'b00001111, 1'b0);
        send({16'hC014, 16'hC013, 16'hC012, 16'hC011}, 8'hFF, 1'b0);
        send({16'hC024, 16'hC023, 16'hC022, 16'hC021}, 8'hFF, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        check("full_tready", 64'(i_tready), 64'd0);
        check("full_fill", 64'(filling_level), 64'd8);
        check("full_head_beat", 64'({o_tvalid, o_tdata}), {31'd0, 1'b1, 32'hC002C001});
        i_tdata  = {16'h9999, 16'h9999, 16'h9999, 16'h9999};
        i_tkeep  = 8'hFF;
        i_tvalid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("full_no_write", 64'(filling_level), 64'd8);
        i_tvalid = 1'b0;
        o_tready = 1'b1;
        drain("drain_full", 50);

        // Wrap and simultaneous push/pop with toggling output ready
        fork
            begin
                for (int k = 0; k < 40; k++) push_pattern(k);
            end
            begin
                repeat (200) begin
                    @(posedge clk);
                    #1 o_tready = ~o_tready;
                end
                o_tready = 1'b1;
            end
        join
        o_tready = 1'b1;
        drain("drain_wrap", 300);

        // Reset mid-packet with 5 entries stored
        o_tready = 1'b0;
        send({16'hE004, 16'hE003, 16'hE002, 16'hE001}, 8'hFF, 1'b0);
        send({16'h0000, 16'hE013, 16'hE012, 16'hE011}, 8'b00111111, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check("pre_rst_fill", 64'(filling_level), 64'd5);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("midrst_tvalid", 64'(o_tvalid), 64'd0);
        check("midrst_fill", 64'(filling_level), 64'd0);
        check("midrst_tready", 64'(i_tready), 64'd0);
        exp_q.delete();
        model_q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1 o_tready = 1'b1;
        exp_q.push_back(mk({16'hF002, 16'hF001}, 4'b1111, 1'b1));
        send({16'h0000, 16'h0000, 16'hF002, 16'hF001}, 8'b00001111, 1'b1);
        drain("drain_post_rst", 50);

        // Timeout flush of a single unterminated lane
`ifdef MULTI_LANE_COMPACT_TIMEOUT_EN
        exp_q.push_back(mk({16'h0000, 16'h7001}, 4'b0011, 1'b0));
`endif
        send({16'h0000, 16'h0000, 16'h0000, 16'h7001}, 8'b00000011, 1'b0);
        c = 0;
        while (c < 40) begin
            @(posedge clk);
            #1;
            c++;
            if (o_tvalid) break;
        end
`ifdef MULTI_LANE_COMPACT_TIMEOUT_EN
        check("timeout_latency", 64'(c), 64'd16);
        drain("drain_timeout", 20);
`else
        check("no_timeout_output", 64'(c), 64'd40);
        check("residue_waits", 64'(filling_level), 64'd1);
`endif

        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
